// File: rtl/usb_uart_pipe_tx.sv
// usb_uart_pipe_tx: 8N1 UART transmitter fed by the USB UART byte pipe.
// A small elastic FIFO absorbs bulk bursts ahead of per-byte serialisation.
module usb_uart_pipe_tx #(
    parameter int CLK_HZ     = 48000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_48mhz,
    input  logic                        reset,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int DIVISOR = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW      = $clog2(DIVISOR);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int LW      = PW + 1;

    localparam logic [CW-1:0] BAUD_LOAD = CW'(DIVISOR - 1);
    localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic          tx_q, tx_d;
    logic [7:0]    shift_q, shift_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic          push;
    logic          pop;
    logic          have_byte;

    assign in_ready   = reset && (level_q != FULL);
    assign push       = in_valid && in_ready;
    assign have_byte  = (level_q != '0);
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || have_byte;
    assign fifo_level = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pops happen only from IDLE or at the end of STOP, so frames chain
    // back-to-back whenever the FIFO still holds a byte.
    always_comb begin
        pop     = 1'b0;
        state_d = state_q;
        tx_d    = tx_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (have_byte) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = BAUD_LOAD;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    state_d = DATA;
                    bit_d   = '0;
                    baud_d  = BAUD_LOAD;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    if (have_byte) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        baud_d  = BAUD_LOAD;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            shift_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            shift_q  <= shift_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk_48mhz) begin
        mem_q <= mem_d;
    end

endmodule
